// File: rtl/alu_result_checker.sv
// alu_result_checker: recomputes 8-bit ALU results, counts pass/fail/skip and captures the first failure
module alu_result_checker #(
  parameter int CNT_W = 16,
  parameter bit STOP_ON_ERR = 1'b1,
  parameter logic [7:0] DIV0_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             smp_vld,
  input  logic [7:0]       smp_a,
  input  logic [7:0]       smp_b,
  input  logic [2:0]       smp_sel,
  input  logic [7:0]       smp_out,
  output logic             chk_vld,
  output logic             chk_fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             halted,
  output logic [7:0]       err_a,
  output logic [7:0]       err_b,
  output logic [2:0]       err_sel,
  output logic [7:0]       err_got,
  output logic [7:0]       err_exp
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [7:0] exp_d;
  logic acc, halt_now, inc_pass, inc_fail, inc_skip;
  logic s_vld_q, s_skip_q, s_fail_q;
  logic [7:0] s_a_q, s_b_q, s_got_q, s_exp_q;
  logic [2:0] s_sel_q;
  logic chk_vld_q, chk_fail_q, err_vld_q;
  logic [CNT_W-1:0] pass_q, fail_q, skip_q;
  logic [7:0] err_a_q, err_b_q, err_got_q, err_exp_q;
  logic [2:0] err_sel_q;
  // Reference result for the vector currently on the sample inputs
  always_comb begin
    exp_d = smp_sel == 3'd0 ? smp_a + smp_b :
            smp_sel == 3'd1 ? smp_a - smp_b :
            smp_sel == 3'd2 ? smp_a & smp_b :
            smp_sel == 3'd3 ? smp_a | smp_b :
            smp_sel == 3'd4 ? ~smp_a :
            smp_sel == 3'd5 ? (smp_b == 8'd0 ? DIV0_VAL : smp_a / smp_b) : 8'd0;
  end
  // A mismatch reported this cycle halts the checker, so the sample arriving alongside it is refused
  always_comb begin
    halt_now = STOP_ON_ERR && s_vld_q && s_fail_q;
    acc = state_q == RUN && en && smp_vld && !clr && !halt_now;
    inc_pass = s_vld_q && !s_skip_q && !s_fail_q;
    inc_fail = s_vld_q && s_fail_q;
    inc_skip = s_vld_q && s_skip_q;
    state_d = clr ? IDLE :
              state_q == IDLE ? (en ? RUN : IDLE) :
              state_q == RUN ? (halt_now ? HALT : en ? RUN : IDLE) : HALT;
  end
  // Checker state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Sample stage: holds the accepted vector with its verdict for one cycle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s_vld_q <= 1'b0;
      s_skip_q <= 1'b0;
      s_fail_q <= 1'b0;
      s_a_q <= 8'd0;
      s_b_q <= 8'd0;
      s_sel_q <= 3'd0;
      s_got_q <= 8'd0;
      s_exp_q <= 8'd0;
    end else begin
      s_vld_q <= acc;
      if (acc) begin
        s_skip_q <= smp_sel[2:1] == 2'b11;
        s_fail_q <= smp_sel[2:1] != 2'b11 && exp_d != smp_out;
        s_a_q <= smp_a;
        s_b_q <= smp_b;
        s_sel_q <= smp_sel;
        s_got_q <= smp_out;
        s_exp_q <= exp_d;
      end
    end
  end
  // Result stage: pulses, saturating counters and first-failure capture
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      chk_vld_q <= 1'b0;
      chk_fail_q <= 1'b0;
      pass_q <= '0;
      fail_q <= '0;
      skip_q <= '0;
      err_vld_q <= 1'b0;
      err_a_q <= 8'd0;
      err_b_q <= 8'd0;
      err_sel_q <= 3'd0;
      err_got_q <= 8'd0;
      err_exp_q <= 8'd0;
    end else begin
      chk_vld_q <= s_vld_q && !s_skip_q;
      chk_fail_q <= inc_fail;
      pass_q <= pass_q + CNT_W'(inc_pass && pass_q != '1);
      fail_q <= fail_q + CNT_W'(inc_fail && fail_q != '1);
      skip_q <= skip_q + CNT_W'(inc_skip && skip_q != '1);
      if (inc_fail && !err_vld_q) begin
        err_vld_q <= 1'b1;
        err_a_q <= s_a_q;
        err_b_q <= s_b_q;
        err_sel_q <= s_sel_q;
        err_got_q <= s_got_q;
        err_exp_q <= s_exp_q;
      end
    end
  end
  assign chk_vld = chk_vld_q;
  assign chk_fail = chk_fail_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign skip_cnt = skip_q;
  assign halted = state_q == HALT;
  assign err_a = err_a_q;
  assign err_b = err_b_q;
  assign err_sel = err_sel_q;
  assign err_got = err_got_q;
  assign err_exp = err_exp_q;
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: scoreboard bench for a halting 16-bit and a free-running 2-bit checker instance
module tb_alu_result_checker;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, smp_vld = 1'b0;
  logic [7:0] smp_a = 8'd0, smp_b = 8'd0, smp_out = 8'd0;
  logic [2:0] smp_sel = 3'd0;
  logic v0, f0, h0, v1, f1, h1;
  logic [15:0] pc0, fc0, sc0;
  logic [1:0] pc1, fc1, sc1;
  logic [7:0] ea0, eb0, eg0, ee0, ea1, eb1, eg1, ee1;
  logic [2:0] es0, es1;
  typedef struct {bit f; bit h; logic [15:0] p; logic [15:0] fl; logic [15:0] s;} ent_t;
  ent_t q[$];
  logic [15:0] m_pc[2], m_fc[2], m_sc[2];
  bit m_h[2], m_ev[2];
  logic [7:0] m_ea[2], m_eb[2], m_eg[2], m_ee[2];
  logic [2:0] m_es[2];
  int n_cmp = 0, n_bad = 0;
  bit run = 1'b0;

  alu_result_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1), .DIV0_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .smp_vld(smp_vld), .smp_a(smp_a), .smp_b(smp_b),
    .smp_sel(smp_sel), .smp_out(smp_out), .chk_vld(v0), .chk_fail(f0), .pass_cnt(pc0),
    .fail_cnt(fc0), .skip_cnt(sc0), .halted(h0), .err_a(ea0), .err_b(eb0), .err_sel(es0),
    .err_got(eg0), .err_exp(ee0));
  alu_result_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0), .DIV0_VAL(8'h00)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .smp_vld(smp_vld), .smp_a(smp_a), .smp_b(smp_b),
    .smp_sel(smp_sel), .smp_out(smp_out), .chk_vld(v1), .chk_fail(f1), .pass_cnt(pc1),
    .fail_cnt(fc1), .skip_cnt(sc1), .halted(h1), .err_a(ea1), .err_b(eb1), .err_sel(es1),
    .err_got(eg1), .err_exp(ee1));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, g, e);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~a;
      3'd5: return b == 8'd0 ? 8'h00 : a / b;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] x, input int i);
    return x == (i == 0 ? 16'hFFFF : 16'd3) ? x : x + 16'd1;
  endfunction

  task automatic m_zero();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 0; m_fc[i] = 0; m_sc[i] = 0; m_h[i] = 0; m_ev[i] = 0;
      m_ea[i] = 0; m_eb[i] = 0; m_eg[i] = 0; m_ee[i] = 0; m_es[i] = 0;
    end
    q.delete();
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, input logic [7:0] o);
    logic [7:0] e;
    bit f;
    e = ref_alu(a, b, s);
    f = o != e;
    for (int i = 0; i < 2; i++) begin
      if (!m_h[i]) begin
        if (s > 3'd5) m_sc[i] = sat(m_sc[i], i);
        else begin
          if (f) begin
            m_fc[i] = sat(m_fc[i], i);
            if (!m_ev[i]) begin
              m_ev[i] = 1; m_ea[i] = a; m_eb[i] = b; m_es[i] = s; m_eg[i] = o; m_ee[i] = e;
            end
            if (i == 0) m_h[i] = 1;
          end else m_pc[i] = sat(m_pc[i], i);
          if (i == 0) q.push_back(ent_t'{f, m_h[0], m_pc[0], m_fc[0], m_sc[0]});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, input logic [7:0] o);
    smp_a = a; smp_b = b; smp_sel = s; smp_out = o; smp_vld = 1'b1;
    if (run) model(a, b, s, o);
    @(posedge clk);
    #1;
    smp_vld = 1'b0;
  endtask

  task automatic send_rand();
    logic [7:0] a, b;
    logic [2:0] s;
    a = 8'($urandom);
    b = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom);
    s = 3'($urandom_range(0, 7));
    send(a, b, s, $urandom_range(0, 5) == 0 ? 8'($urandom) : ref_alu(a, b, s));
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_zero();
    idle(1);
  endtask

  task automatic check_pt(input string tag);
    chk({tag, ".pending"}, q.size(), 0);
    chk({tag, ".pass0"}, pc0, m_pc[0]);
    chk({tag, ".fail0"}, fc0, m_fc[0]);
    chk({tag, ".skip0"}, sc0, m_sc[0]);
    chk({tag, ".halt0"}, h0, m_h[0]);
    chk({tag, ".err0"}, {ea0, eb0, es0, eg0}, {m_ea[0], m_eb[0], m_es[0], m_eg[0]});
    chk({tag, ".errexp0"}, ee0, m_ee[0]);
    chk({tag, ".pass1"}, pc1, m_pc[1]);
    chk({tag, ".fail1"}, fc1, m_fc[1]);
    chk({tag, ".skip1"}, sc1, m_sc[1]);
    chk({tag, ".halt1"}, h1, 0);
    chk({tag, ".err1"}, {ea1, eb1, es1, eg1}, {m_ea[1], m_eb[1], m_es[1], m_eg[1]});
    chk({tag, ".errexp1"}, ee1, m_ee[1]);
  endtask

  always @(negedge clk) begin
    if (v0) begin
      if (q.size() == 0) chk("unexpected_chk_vld", 1, 0);
      else begin
        ent_t e;
        e = q.pop_front();
        chk("mon.chk_fail", f0, e.f);
        chk("mon.pass_cnt", pc0, e.p);
        chk("mon.fail_cnt", fc0, e.fl);
        chk("mon.skip_cnt", sc0, e.s);
        chk("mon.halted", h0, e.h);
      end
    end
  end

  initial begin
    m_zero();
    idle(3);
    check_pt("reset");
    chk("reset.vld", {v0, f0, v1, f1}, 0);
    rst = 1'b0;
    en = 1'b1;
    idle(2);
    run = 1'b1;
    send(12, 4, 3'd0, 16);
    chk("add.lat0", v0, 0);
    idle(1);
    chk("add.vld", v0, 1);
    chk("add.fail", f0, 0);
    chk("add.pass", pc0, 1);
    send(12, 4, 3'd1, 8);
    send(12, 4, 3'd2, 4);
    send(12, 4, 3'd3, 12);
    send(12, 4, 3'd4, 243);
    send(12, 4, 3'd5, 3);
    idle(2);
    check_pt("opcodes");
    chk("opcodes.pass", pc0, 6);
    chk("opcodes.fail", fc0, 0);
    send(12, 0, 3'd5, 8'h00);
    send(12, 0, 3'd5, 8'hFF);
    idle(2);
    check_pt("div0");
    chk("div0.fail", fc0, 1);
    clr_pulse();
    send(200, 100, 3'd0, 44);
    send(200, 100, 3'd1, 0);
    send(200, 100, 3'd0, 44);
    send(1, 1, 3'd6, 0);
    send(9, 3, 3'd1, 1);
    idle(2);
    check_pt("halt");
    chk("halt.halted", h0, 1);
    chk("halt.err_exp", ee0, 100);
    chk("halt.err_got", eg0, 0);
    chk("halt.err_sel", es0, 1);
    chk("halt.pass", pc0, 1);
    clr_pulse();
    check_pt("halt_clr");
    chk("halt_clr.halted", h0, 0);
    send(1, 2, 3'd6, 0);
    idle(2);
    check_pt("skip");
    chk("skip.cnt", sc0, 1);
    clr_pulse();
    repeat (5) send(3, 4, 3'd0, 7);
    idle(2);
    check_pt("sat");
    chk("sat.pass1", pc1, 3);
    en = 1'b0;
    run = 1'b0;
    idle(2);
    repeat (3) send(5, 5, 3'd0, 10);
    idle(2);
    check_pt("gate");
    en = 1'b1;
    idle(2);
    run = 1'b1;
    send(7, 1, 3'd0, 8);
    smp_a = 7; smp_b = 1; smp_sel = 3'd0; smp_out = 8; smp_vld = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    smp_vld = 1'b0;
    clr = 1'b0;
    m_zero();
    idle(3);
    check_pt("clr_smp");
    repeat (6) begin
      clr_pulse();
      repeat (40) send_rand();
      idle(2);
      check_pt("rand");
    end
    repeat (5) send_rand();
    smp_vld = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_zero();
    check_pt("rst_mid");
    chk("rst_mid.vld", {v0, f0, v1, f1}, 0);
    rst = 1'b0;
    smp_vld = 1'b0;
    idle(2);
    send(20, 5, 3'd1, 15);
    idle(2);
    check_pt("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
